regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-side controller for the 64-bit x 32-entry integer register file.
//  Accepts writeback requests (rd, data) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
//  Issues at most one register-file write per cycle on RegWrite/RD/WriteData.
//  Keeps a per-register pending scoreboard so decode can stall RAW hazards on RS1/RS2.
// PARAMETERS
//  DATA_W  64  register width
//  ADDR_W  5   register address width (2**ADDR_W registers)
//  DEPTH   4   writeback FIFO entries; power of 2, >=2
// PORTS
//  clk           in   1       system clock, all state on posedge
//  reset         in   1       asynchronous, active-low reset
//  wb_valid      in   1       writeback request valid
//  wb_ready      out  1       request accepted on an edge where wb_valid&&wb_ready
//  wb_rd         in   ADDR_W  destination register
//  wb_data       in   DATA_W  destination data
//  rf_stall      in   1       register-file write port unavailable this cycle; inhibit issue
//  RegWrite      out  1       register-file write enable (registered)
//  RD            out  ADDR_W  register-file write address (registered)
//  WriteData     out  DATA_W  register-file write data (registered)
//  q_rs1, q_rs2  in   ADDR_W  decode source registers to check
//  q_hazard1/2   out  1       source has a write pending (combinational from state + q_rs*)
//  idle          out  1       FIFO empty and RegWrite low
// BEHAVIOUR
//  Reset (reset=0, async): FIFO pointers/count=0; RegWrite=0, RD=0, WriteData=0;
//   all scoreboard counters=0; hence wb_ready=1, q_hazard*=0, idle=1. Reset mid-burst discards all queued writes.
//  Handshake: wb_ready = !full (state only, never depends on wb_valid). wb_data/wb_rd sampled on the accepting edge.
//  rd=0: request accepted (handshake completes) but dropped; not queued, no scoreboard change; x0 never written.
//  Issue FSM, 2 states:
//   IDLE  -> ISSUE when FIFO non-empty && !rf_stall
//   ISSUE -> ISSUE when FIFO non-empty && !rf_stall, else IDLE
//   On entering/remaining in ISSUE: pop head into RD/WriteData, RegWrite=1 for that cycle. In IDLE: RegWrite=0, RD/WriteData hold.
//  Latency: accept at edge N into empty FIFO with rf_stall=0 -> RegWrite=1 in cycle after edge N+1
//   (FIFO write at N, issue register at N+1). Throughput: 1 write/cycle sustained.
//  Ordering: strict FIFO; two writes to same rd issue in acceptance order.
//  Full: count==DEPTH -> wb_ready=0. A push and a pop on the same edge are both legal when not full;
//   count unchanged. Pointers wrap modulo DEPTH.
//  Scoreboard: pend[r], width clog2(DEPTH+2), one per register.
//   +1 on the accepting edge (r!=0); -1 on the edge ending a cycle with RegWrite=1 && RD==r.
//   Both on same edge for same r -> unchanged. Never overflows by construction (<=DEPTH+1).
//  q_hazardN = (q_rsN!=0) && (pend[q_rsN]!=0). Stays high through the RegWrite cycle; low the cycle after.
//   The regfile read is registered in the same edge.
//  idle = (count==0) && !RegWrite.
// TESTING
//  1 Write rd=5, data=64'hDEAD accepted edge 1, rf_stall=0 -> RegWrite=1,RD=5,WriteData=DEAD in cycle 2 only;
//    q_rs1=5 gives hazard1=1 cycles 1-2, 0 from cycle 3; idle=1 from cycle 3.
//  2 rf_stall=1, push 4 distinct writes -> wb_ready=0 after 4th; 5th valid held, not accepted.
//    Release stall -> 4 issues back-to-back in order, 5th then accepted and issued.
//  3 Push rd=0 data=FFFF -> handshake completes; no RegWrite; hazard for rs=0 always 0; idle stays 1.
//  4 Push rd=7 twice (A then B) -> pend[7]=2; hazard1 (q_rs1=7) held until cycle after B issues; RD=7 writes A then B.
//  5 Simultaneous push rd=3 while issuing rd=3 -> pend[3] unchanged at 1; hazard stays 1 until second issue.
//  6 Assert reset with 3 queued -> RegWrite=0, wb_ready=1, all hazards 0, idle=1 immediately; no queued write issues after release.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request channel into the register-file write controller.
// valid/ready handshake carrying destination register and data.
interface regfile_wb_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output wb_valid,
    output wb_rd,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_rd,
    input  wb_data,
    output wb_ready
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write controller: FIFO-buffered writeback requests,
// one registered write per cycle, per-register pending scoreboard.
module regfile_wb_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_ctrl_if.slave  wb,
  input  logic              rf_stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              q_hazard1,
  output logic              q_hazard2,
  output logic              idle
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int PW   = $clog2(DEPTH + 2);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]     r_pend     [NREG];
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  logic w_full;
  logic w_acc;
  logic w_push;
  logic w_pop;

  assign w_full      = (r_count == CW'(DEPTH));
  assign wb.wb_ready = !w_full;
  assign w_acc       = wb.wb_valid && !w_full;
  // x0 requests complete the handshake but never enter the queue
  assign w_push      = w_acc && (wb.wb_rd != '0);
  assign w_pop       = (r_count != '0) && !rf_stall;

  assign RegWrite  = (r_state == S_ISSUE);
  assign RD        = r_rd;
  assign WriteData = r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ISSUE: begin
          if (w_pop) begin
            r_state <= S_ISSUE;
            r_rd    <= r_mem_rd[r_rptr];
            r_data  <= r_mem_data[r_rptr];
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= wb.wb_rd;
      r_mem_data[r_wptr] <= wb.wb_data;
    end
  end

  // Entry leaves the scoreboard at the end of its RegWrite cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_push && wb.wb_rd == ADDR_W'(i) &&
            !(RegWrite && r_rd == ADDR_W'(i)))
          r_pend[i] <= r_pend[i] + PW'(1);
        else if (!(w_push && wb.wb_rd == ADDR_W'(i)) &&
                 RegWrite && r_rd == ADDR_W'(i))
          r_pend[i] <= r_pend[i] - PW'(1);
      end
    end
  end

  assign q_hazard1 = (q_rs1 != '0) && (r_pend[q_rs1] != '0);
  assign q_hazard2 = (q_rs2 != '0) && (r_pend[q_rs2] != '0);
  assign idle      = (r_count == '0) && !RegWrite;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_regfile_wb_ctrl;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int DP = 4;

  logic          clk;
  logic          reset;
  logic          rf_stall;
  logic          RegWrite;
  logic [AW-1:0] RD;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] q_rs1;
  logic [AW-1:0] q_rs2;
  logic          q_hazard1;
  logic          q_hazard2;
  logic          idle;

  int total = 0;
  int bad   = 0;

  regfile_wb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) wbif ();

  regfile_wb_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wbif),
    .rf_stall (rf_stall),
    .RegWrite (RegWrite),
    .RD       (RD),
    .WriteData(WriteData),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_hazard1(q_hazard1),
    .q_hazard2(q_hazard2),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  bit            m_rw;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  bit            m_acc;

  function automatic bit m_haz(logic [AW-1:0] rs);
    if (rs == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return m_rw && (m_rd == rs);
  endfunction

  task automatic m_clear();
    mq.delete();
    m_rw   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_acc  = 1'b0;
  endtask

  // Model the edge from pre-edge inputs, then advance and settle
  task automatic tick();
    ent_t e;
    bit   rdy;
    rdy   = (mq.size() < DP);
    m_acc = wbif.wb_valid && rdy;
    if (mq.size() > 0 && !rf_stall) begin
      e      = mq.pop_front();
      m_rw   = 1'b1;
      m_rd   = e.rd;
      m_data = e.data;
    end else begin
      m_rw = 1'b0;
    end
    if (m_acc && wbif.wb_rd != 0) begin
      e.rd   = wbif.wb_rd;
      e.data = wbif.wb_data;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [AW-1:0] rd, logic [DW-1:0] d);
    wbif.wb_valid = v;
    wbif.wb_rd    = rd;
    wbif.wb_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    m_clear();
    total++;
    if (RegWrite !== 1'b0 || RD !== '0 || WriteData !== '0) begin
      bad++;
      $display("FAIL reset_out got rw=%b rd=%0d wd=%h want 0/0/0",
               RegWrite, RD, WriteData);
    end
    total++;
    if (wbif.wb_ready !== 1'b1 || idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_rdy_idle got %b/%b want 1/1",
               wbif.wb_ready, idle);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    total++;
    if (idle !== 1'b1 || q_hazard1 !== 1'b0 || q_hazard2 !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got idle=%b h=%b%b want 1 00",
               idle, q_hazard1, q_hazard2);
    end
  endtask

  task automatic test_single();
    q_rs1 = 5;
    drive(1'b1, 5, 64'hDEAD);
    total++;
    if (wbif.wb_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_rdy got %b want 1", wbif.wb_ready);
    end
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (q_hazard1 !== 1'b1 || RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL single_c1 got h=%b rw=%b want 1/0",
               q_hazard1, RegWrite);
    end
    tick();
    total++;
    if (RegWrite !== 1'b1 || RD !== 5'd5 || WriteData !== 64'hDEAD ||
        q_hazard1 !== 1'b1) begin
      bad++;
      $display("FAIL single_c2 got rw=%b rd=%0d wd=%h h=%b want 1/5/dead/1",
               RegWrite, RD, WriteData, q_hazard1);
    end
    tick();
    total++;
    if (RegWrite !== 1'b0 || q_hazard1 !== 1'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL single_c3 got rw=%b h=%b idle=%b want 0/0/1",
               RegWrite, q_hazard1, idle);
    end
  endtask

  task automatic test_full();
    logic [AW-1:0] exp [5];
    exp = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20};
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, exp[i], 64'(100 + i));
      tick();
    end
    total++;
    if (wbif.wb_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_rdy got %b want 0", wbif.wb_ready);
    end
    drive(1'b1, exp[4], 64'd500);
    tick();
    total++;
    if (wbif.wb_ready !== 1'b0 || RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL full_hold got rdy=%b rw=%b want 0/0",
               wbif.wb_ready, RegWrite);
    end
    rf_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_acc) drive(1'b0, 0, 0);
      total++;
      if (RegWrite !== 1'b1 || RD !== exp[i]) begin
        bad++;
        $display("FAIL full_order[%0d] got rw=%b rd=%0d want 1/%0d",
                 i, RegWrite, RD, exp[i]);
      end
    end
    drive(1'b0, 0, 0);
    tick();
    total++;
    if (idle !== 1'b1) begin
      bad++;
      $display("FAIL full_drain got idle=%b want 1", idle);
    end
  endtask

  task automatic test_rd0();
    q_rs1 = 0;
    q_rs2 = 0;
    drive(1'b1, 0, 64'hFFFF);
    total++;
    if (wbif.wb_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd0_rdy got %b want 1", wbif.wb_ready);
    end
    tick();
    drive(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (RegWrite !== 1'b0 || idle !== 1'b1 ||
          q_hazard1 !== 1'b0 || q_hazard2 !== 1'b0) begin
        bad++;
        $display("FAIL rd0[%0d] got rw=%b idle=%b h=%b%b want 0/1/00",
                 i, RegWrite, idle, q_hazard1, q_hazard2);
      end
      tick();
    end
  endtask

  task automatic test_same_rd();
    q_rs1 = 7;
    q_rs2 = 7;
    drive(1'b1, 7, 64'hAAAA);
    tick();
    drive(1'b1, 7, 64'hBBBB);
    total++;
    if (q_hazard1 !== 1'b1 || q_hazard2 !== 1'b1) begin
      bad++;
      $display("FAIL same_c1 got h=%b%b want 11", q_hazard1, q_hazard2);
    end
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (RegWrite !== 1'b1 || RD !== 5'd7 || WriteData !== 64'hAAAA ||
        q_hazard1 !== 1'b1) begin
      bad++;
      $display("FAIL same_a got rw=%b rd=%0d wd=%h h=%b want 1/7/aaaa/1",
               RegWrite, RD, WriteData, q_hazard1);
    end
    tick();
    total++;
    if (RegWrite !== 1'b1 || RD !== 5'd7 || WriteData !== 64'hBBBB ||
        q_hazard1 !== 1'b1) begin
      bad++;
      $display("FAIL same_b got rw=%b rd=%0d wd=%h h=%b want 1/7/bbbb/1",
               RegWrite, RD, WriteData, q_hazard1);
    end
    tick();
    total++;
    if (RegWrite !== 1'b0 || q_hazard1 !== 1'b0 || q_hazard2 !== 1'b0) begin
      bad++;
      $display("FAIL same_end got rw=%b h=%b%b want 0/00",
               RegWrite, q_hazard1, q_hazard2);
    end
  endtask

  task automatic test_collide();
    q_rs1 = 3;
    drive(1'b1, 3, 64'h1111);
    tick();
    drive(1'b0, 0, 0);
    tick();
    drive(1'b1, 3, 64'h2222);
    total++;
    if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 64'h1111) begin
      bad++;
      $display("FAIL col_x got rw=%b rd=%0d wd=%h want 1/3/1111",
               RegWrite, RD, WriteData);
    end
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (q_hazard1 !== 1'b1 || RegWrite !== 1'b0) begin
      bad++;
      $display("FAIL col_mid got h=%b rw=%b want 1/0", q_hazard1, RegWrite);
    end
    tick();
    total++;
    if (RegWrite !== 1'b1 || WriteData !== 64'h2222 ||
        q_hazard1 !== 1'b1) begin
      bad++;
      $display("FAIL col_y got rw=%b wd=%h h=%b want 1/2222/1",
               RegWrite, WriteData, q_hazard1);
    end
    tick();
    total++;
    if (q_hazard1 !== 1'b0) begin
      bad++;
      $display("FAIL col_end got h=%b want 0", q_hazard1);
    end
  endtask

  task automatic test_reset_mid();
    rf_stall = 1'b1;
    q_rs1 = 1;
    q_rs2 = 2;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, AW'(i), 64'(i));
      tick();
    end
    drive(1'b0, 0, 0);
    total++;
    if (q_hazard1 !== 1'b1 || q_hazard2 !== 1'b1 || idle !== 1'b0) begin
      bad++;
      $display("FAIL rmid_pre got h=%b%b idle=%b want 11/0",
               q_hazard1, q_hazard2, idle);
    end
    reset = 1'b0;
    #1;
    m_clear();
    total++;
    if (RegWrite !== 1'b0 || wbif.wb_ready !== 1'b1 || idle !== 1'b1 ||
        q_hazard1 !== 1'b0 || q_hazard2 !== 1'b0) begin
      bad++;
      $display("FAIL rmid_now got rw=%b rdy=%b idle=%b h=%b%b want 0/1/1/00",
               RegWrite, wbif.wb_ready, idle, q_hazard1, q_hazard2);
    end
    @(negedge clk);
    reset    = 1'b1;
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (RegWrite !== 1'b0 || idle !== 1'b1) begin
        bad++;
        $display("FAIL rmid_after[%0d] got rw=%b idle=%b want 0/1",
                 i, RegWrite, idle);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)),
            {$urandom, $urandom});
      rf_stall = ($urandom_range(0, 3) == 0);
      q_rs1    = AW'($urandom_range(0, 7));
      q_rs2    = AW'($urandom_range(0, 7));
      #1;
      total++;
      if (wbif.wb_ready !== (mq.size() < DP) ||
          q_hazard1 !== m_haz(q_rs1) || q_hazard2 !== m_haz(q_rs2)) begin
        bad++;
        $display("FAIL rnd_comb[%0d] got rdy=%b h=%b%b want %b %b%b", c,
                 wbif.wb_ready, q_hazard1, q_hazard2,
                 mq.size() < DP, m_haz(q_rs1), m_haz(q_rs2));
      end
      tick();
      total++;
      if (RegWrite !== m_rw || RD !== m_rd || WriteData !== m_data ||
          idle !== (mq.size() == 0 && !m_rw)) begin
        bad++;
        $display("FAIL rnd_out[%0d] got rw=%b rd=%0d wd=%h idle=%b want %b %0d %h %b",
                 c, RegWrite, RD, WriteData, idle, m_rw, m_rd, m_data,
                 mq.size() == 0 && !m_rw);
      end
    end
    drive(1'b0, 0, 0);
    rf_stall = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    rf_stall = 1'b0;
    q_rs1    = '0;
    q_rs2    = '0;
    drive(1'b0, 0, 0);
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_full();
    test_rd0();
    test_same_rd();
    test_collide();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
